// File: rtl/sclk_burst_generator.sv
// Programmable even-ratio serial clock generator with lead/trail edge strobes and counted or continuous bursts.
// Latency: busy one edge after start; first leading edge H edges after start; done with the final trailing edge.
// No backpressure: start is accepted only in IDLE; abort (or reset) stops the burst on the next edge.
module sclk_burst_generator #(
  parameter int DIV_WIDTH   = 8,
  parameter int BURST_WIDTH = 8
) (
  input  logic                   CLK100MHZ,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   abort,
  input  logic [DIV_WIDTH-1:0]   divide,
  input  logic [BURST_WIDTH-1:0] burst_len,
  input  logic                   cpol,
  output logic                   sclk,
  output logic                   lead_strobe,
  output logic                   trail_strobe,
  output logic                   busy,
  output logic                   done
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [DIV_WIDTH-2:0] H_ONE = 1;
  localparam logic [BURST_WIDTH:0] E_ONE = 1;

  state_t                 state, state_nxt;
  logic [DIV_WIDTH-2:0]   h_reg, h_nxt;
  logic [BURST_WIDTH-1:0] len_reg, len_nxt;
  logic                   pol_reg, pol_nxt;
  logic [DIV_WIDTH-2:0]   cnt, cnt_nxt;
  logic [BURST_WIDTH:0]   edges, edges_nxt;
  logic                   sclk_nxt, lead_nxt, trail_nxt, busy_nxt, done_nxt;

  logic [DIV_WIDTH-2:0]   half;
  logic [DIV_WIDTH-2:0]   h_new;
  logic [BURST_WIDTH:0]   edges_inc;
  logic                   last_trail;

  // Half period from the requested ratio; ratios below 4 collapse to the fastest legal H = 1.
  assign half       = divide[DIV_WIDTH-1:1];
  assign h_new      = (half == '0) ? H_ONE : half;
  assign edges_inc  = edges + E_ONE;
  assign last_trail = (len_reg != '0) && (edges_inc == {1'b0, len_reg});

  // Register all state and outputs; synchronous reset returns everything to idle with polarity 0.
  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      state        <= IDLE;
      h_reg        <= H_ONE;
      len_reg      <= '0;
      pol_reg      <= 1'b0;
      cnt          <= '0;
      edges        <= '0;
      sclk         <= 1'b0;
      lead_strobe  <= 1'b0;
      trail_strobe <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      state        <= state_nxt;
      h_reg        <= h_nxt;
      len_reg      <= len_nxt;
      pol_reg      <= pol_nxt;
      cnt          <= cnt_nxt;
      edges        <= edges_nxt;
      sclk         <= sclk_nxt;
      lead_strobe  <= lead_nxt;
      trail_strobe <= trail_nxt;
      busy         <= busy_nxt;
      done         <= done_nxt;
    end
  end

  // Next-state logic: latch on start, count half periods in RUN, stop on final trail edge or abort.
  always_comb begin
    state_nxt = state;
    h_nxt     = h_reg;
    len_nxt   = len_reg;
    pol_nxt   = pol_reg;
    cnt_nxt   = cnt;
    edges_nxt = edges;
    sclk_nxt  = sclk;
    lead_nxt  = 1'b0;
    trail_nxt = 1'b0;
    done_nxt  = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RUN;
          h_nxt     = h_new;
          len_nxt   = burst_len;
          pol_nxt   = cpol;
          sclk_nxt  = cpol;
          cnt_nxt   = h_new - H_ONE;
          edges_nxt = '0;
        end
      end
      RUN: begin
        if (cnt != '0) begin
          cnt_nxt = cnt - H_ONE;
        end else begin
          cnt_nxt = h_reg - H_ONE;
          if (sclk == pol_reg) begin
            sclk_nxt = ~pol_reg;
            lead_nxt = 1'b1;
          end else begin
            sclk_nxt  = pol_reg;
            trail_nxt = 1'b1;
            // Saturate so a long continuous run never wraps back to zero.
            edges_nxt = (&edges) ? edges : edges_inc;
            if (last_trail) begin
              state_nxt = IDLE;
              done_nxt  = 1'b1;
            end
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Abort overrides everything, including a start seen in IDLE; the latched polarity is kept.
    if (abort) begin
      state_nxt = IDLE;
      h_nxt     = h_reg;
      len_nxt   = len_reg;
      pol_nxt   = pol_reg;
      cnt_nxt   = cnt;
      edges_nxt = edges;
      sclk_nxt  = pol_reg;
      lead_nxt  = 1'b0;
      trail_nxt = 1'b0;
      done_nxt  = 1'b0;
    end

    busy_nxt = (state_nxt == RUN);
  end

endmodule

// File: tb/tb_sclk_burst_generator.sv
// Bench for sclk_burst_generator: timing model computed from burst parameters, events checked via a queue.
// Strobe events are queued when a start is issued and popped by a negedge monitor.
// sclk/busy are checked every cycle against a closed-form expectation.
module tb_sclk_burst_generator;

  localparam int K_LEAD  = 0;
  localparam int K_TRAIL = 1;
  localparam int K_DONE  = 2;

  typedef struct {
    int kind;
    int cyc;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] divide = 8'd4;
  logic [7:0] burst_len = 8'd0;
  logic       cpol = 1'b0;
  logic       sclk, lead_strobe, trail_strobe, busy, done;

  int  cyc = 0;
  int  tests = 0;
  int  fails = 0;
  bit  mon_en = 1'b0;
  ev_t q[$];

  // Model of the current/last burst, in absolute edge numbers.
  int m_k = 0, m_h = 1, m_bend = 0;
  int m_p = 0, m_pend = 0, m_prevp = 0;

  sclk_burst_generator #(.DIV_WIDTH(8), .BURST_WIDTH(8)) dut (
    .CLK100MHZ   (clk),
    .reset       (rst),
    .start       (start),
    .abort       (abort),
    .divide      (divide),
    .burst_len   (burst_len),
    .cpol        (cpol),
    .sclk        (sclk),
    .lead_strobe (lead_strobe),
    .trail_strobe(trail_strobe),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic match(input int kind, input int c);
    tests++;
    if (q.size() > 0 && q[0].cyc == c && q[0].kind == kind) begin
      void'(q.pop_front());
    end else begin
      fails++;
      if (q.size() > 0)
        $display("FAIL strobe kind %0d at cycle %0d: expected kind %0d at cycle %0d", kind, c, q[0].kind, q[0].cyc);
      else
        $display("FAIL strobe kind %0d at cycle %0d: expected no event", kind, c);
    end
  endtask

  // Monitor: compares each cycle's outputs against the model and the event queue.
  always @(negedge clk) begin
    if (mon_en) begin
      int c, es, eb;
      c = cyc;
      if (c < m_k) begin
        es = m_prevp; eb = 0;
      end else if (c < m_bend) begin
        eb = 1; es = m_p ^ (((c - m_k) / m_h) % 2);
      end else begin
        eb = 0; es = m_pend;
      end
      check("sclk", int'(sclk), es);
      check("busy", int'(busy), eb);
      while (q.size() > 0 && q[0].cyc < c) begin
        tests++; fails++;
        $display("FAIL missed kind %0d: got none by cycle %0d expected at cycle %0d", q[0].kind, c, q[0].cyc);
        void'(q.pop_front());
      end
      if (lead_strobe && trail_strobe) check("lead_and_trail", 1, 0);
      if (lead_strobe)  match(K_LEAD, c);
      if (trail_strobe) match(K_TRAIL, c);
      if (done)         match(K_DONE, c);
    end
  end

  // Issue one burst; stop_kind 1 = abort, 2 = reset, sampled at edge k+stop_after.
  task automatic run_burst(input int d, input int n, input int p,
                           input int stop_after, input int stop_kind, input bit junk);
    int k, h, s, bend, pend;
    k = cyc + 1;
    h = d / 2;
    if (h < 1) h = 1;
    s = (stop_after > 0) ? k + stop_after : 0;
    bend = (n > 0) ? k + 2 * n * h : 0;
    if (stop_after > 0 && (n == 0 || s < bend)) bend = s;
    pend = (stop_after > 0 && stop_kind == 2) ? 0 : p;
    for (int i = 1; n == 0 || i <= n; i++) begin
      int l, t;
      l = k + (2 * i - 1) * h;
      if (stop_after > 0 && l >= s) break;
      q.push_back('{K_LEAD, l});
      t = k + 2 * i * h;
      if (stop_after > 0 && t >= s) break;
      q.push_back('{K_TRAIL, t});
      if (n != 0 && i == n) q.push_back('{K_DONE, t});
    end
    m_prevp = m_pend;
    m_k = k; m_h = h; m_p = p; m_bend = bend; m_pend = pend;
    divide = 8'(d); burst_len = 8'(n); cpol = p[0]; start = 1'b1;
    do begin
      @(posedge clk); #2;
      start = 1'b0; abort = 1'b0; rst = 1'b0;
      if (stop_after > 0 && cyc == s - 1) begin
        if (stop_kind == 2) rst = 1'b1; else abort = 1'b1;
      end else if (junk && cyc + 1 < bend && $urandom_range(0, 3) == 0) begin
        start = 1'b1;
        divide = 8'($urandom);
        burst_len = 8'($urandom);
        cpol = 1'($urandom);
      end
    end while (cyc < bend);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #2;
    check("reset_sclk", int'(sclk), 0);
    check("reset_lead", int'(lead_strobe), 0);
    check("reset_trail", int'(trail_strobe), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    rst = 1'b0;
    m_k = cyc + 1; m_bend = m_k;
    mon_en = 1'b1;
    idle(4);

    run_burst(4, 3, 0, 0, 0, 1'b0);
    run_burst(5, 2, 0, 0, 0, 1'b0);
    idle(2);
    run_burst(1, 2, 0, 0, 0, 1'b0);
    run_burst(6, 1, 1, 0, 0, 1'b0);
    idle(3);
    run_burst(2, 0, 0, 7, 1, 1'b0);
    idle(1);
    run_burst(4, 3, 1, 0, 0, 1'b1);
    run_burst(4, 3, 1, 5, 2, 1'b0);
    idle(2);
    run_burst(3, 2, 1, 4, 1, 1'b0);
    idle(1);

    for (int i = 0; i < 14; i++) begin
      int d, n, p, st, sk, hh;
      d = $urandom_range(0, 12);
      n = $urandom_range(0, 5);
      p = $urandom_range(0, 1);
      hh = (d / 2 < 1) ? 1 : d / 2;
      st = 0; sk = 1;
      if (n == 0) st = $urandom_range(1, 40);
      else if ($urandom_range(0, 3) == 0) st = $urandom_range(1, 2 * n * hh);
      if (st > 0) sk = $urandom_range(1, 2);
      run_burst(d, n, p, st, sk, 1'($urandom));
      idle($urandom_range(0, 3));
    end

    idle(5);
    check("queue_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
